// File: rtl/freq_bram_writer_pkg.sv
// Shared definitions for the waterfall frequency BRAM.
// Used by the write side (freq_bram_writer) and by the display-side reader.
//   DEF_BINS_W / DEF_ADDR_W : default geometry of the waterfall buffer
//   BINS / ROWS             : bins per row and rows in the circular buffer
//   wr_state_e              : write-side FSM state encoding
package freq_bram_writer_pkg;

  localparam int DEF_BINS_W = 5;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_ROWS_W = DEF_ADDR_W - DEF_BINS_W;
  localparam int BINS       = 1 << DEF_BINS_W;
  localparam int ROWS       = 1 << DEF_ROWS_W;

  typedef enum logic [1:0] {
    RUN  = 2'd0,  // accepting bins of the current row
    FILL = 2'd1,  // short frame: padding the rest of the row with zeros
    DROP = 2'd2   // long frame: discarding bins past the end of the row
  } wr_state_e;

endpackage

// File: rtl/freq_bram_writer.sv
// Write side of the waterfall frequency BRAM.
// Takes a stream of unsigned spectrum magnitudes (one frame = one row of
// bins), scales and saturates each to DATA_W bits and writes it into a
// circular buffer of ROWS x BINS words. Reports the newest completed row.
// Ports:
//   clk        : single clock, also the BRAM w_clk
//   reset      : synchronous, active-high
//   s_valid    : input magnitude valid
//   s_ready    : block can accept a magnitude
//   s_data     : magnitude, unsigned, IN_W bits
//   s_last     : final bin of a frame
//   w_en       : BRAM write enable (one cycle per write)
//   w_addr     : BRAM write address {row, bin}
//   d_in       : BRAM write data
//   top_row    : newest completed row
//   frame_done : one-cycle pulse when a row completes
module freq_bram_writer
  import freq_bram_writer_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 8,
  parameter int BINS_W = DEF_BINS_W,
  parameter int IN_W   = 16,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  output logic                     w_en,
  output logic [ADDR_W-1:0]        w_addr,
  output logic [DATA_W-1:0]        d_in,
  output logic [ADDR_W-BINS_W-1:0] top_row,
  output logic                     frame_done
);

  localparam int ROW_W = ADDR_W - BINS_W;
  localparam logic [IN_W-1:0] SAT_LIMIT = IN_W'((2 ** DATA_W) - 1);

  // Scaled magnitude clamped to the largest word the BRAM can hold.
  function automatic logic [DATA_W-1:0] saturate(input logic [IN_W-1:0] mag);
    logic [IN_W-1:0] v;
    v = mag >> SHIFT;
    if (v > SAT_LIMIT) begin
      return '1;
    end
    return v[DATA_W-1:0];
  endfunction

  wr_state_e          state_reg, state_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [BINS_W-1:0]  bin_reg, bin_next;
  logic               ready_reg, ready_next;
  logic               w_en_reg, w_en_next;
  logic [ADDR_W-1:0]  w_addr_reg, w_addr_next;
  logic [DATA_W-1:0]  d_in_reg, d_in_next;
  logic [ROW_W-1:0]   top_row_reg, top_row_next;
  logic               frame_done_reg, frame_done_next;
  logic               frame_complete;
  logic               accept;
  logic               bin_is_last;

  assign accept      = s_valid && ready_reg;
  assign bin_is_last = (bin_reg == '1);

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    bin_next        = bin_reg;
    w_en_next       = 1'b0;
    w_addr_next     = w_addr_reg;
    d_in_next       = d_in_reg;
    top_row_next    = top_row_reg;
    frame_done_next = 1'b0;
    frame_complete  = 1'b0;

    case (state_reg)
      RUN: begin
        if (accept) begin
          w_en_next   = 1'b1;
          w_addr_next = {row_reg, bin_reg};
          d_in_next   = saturate(s_data);
          if (s_last && bin_is_last) begin
            frame_complete = 1'b1;
          end else if (s_last) begin
            state_next = FILL;
            bin_next   = bin_reg + BINS_W'(1);
          end else if (bin_is_last) begin
            state_next = DROP;
          end else begin
            bin_next = bin_reg + BINS_W'(1);
          end
        end
      end
      FILL: begin
        w_en_next   = 1'b1;
        w_addr_next = {row_reg, bin_reg};
        d_in_next   = '0;
        if (bin_is_last) begin
          frame_complete = 1'b1;
        end else begin
          bin_next = bin_reg + BINS_W'(1);
        end
      end
      DROP: begin
        if (accept && s_last) begin
          frame_complete = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase

    // The completion pulse is registered alongside the final write, so it
    // lines up with that write's w_en (or trails the dropped s_last by one).
    if (frame_complete) begin
      frame_done_next = 1'b1;
      top_row_next    = row_reg;
      row_next        = row_reg + ROW_W'(1);
      bin_next        = '0;
      state_next      = RUN;
    end

    // Ready is registered from the next state so it is low exactly while
    // the zero padding is being written.
    ready_next = (state_next != FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= RUN;
      row_reg        <= '0;
      bin_reg        <= '0;
      ready_reg      <= 1'b0;
      w_en_reg       <= 1'b0;
      w_addr_reg     <= '0;
      d_in_reg       <= '0;
      top_row_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      bin_reg        <= bin_next;
      ready_reg      <= ready_next;
      w_en_reg       <= w_en_next;
      w_addr_reg     <= w_addr_next;
      d_in_reg       <= d_in_next;
      top_row_reg    <= top_row_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign s_ready    = ready_reg;
  assign w_en       = w_en_reg;
  assign w_addr     = w_addr_reg;
  assign d_in       = d_in_reg;
  assign top_row    = top_row_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_freq_bram_writer.sv
// Testbench for freq_bram_writer: random frames checked against a frame-level
// reference model of the expected BRAM write / frame_done event stream.
module tb_freq_bram_writer;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int BINS_W = 5;
  localparam int IN_W   = 16;
  localparam int SHIFT  = 4;
  localparam int BINS   = 32;
  localparam int ROWS   = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [IN_W-1:0]          s_data = '0;
  logic                     s_last = 1'b0;
  logic                     w_en;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        d_in;
  logic [ADDR_W-BINS_W-1:0] top_row;
  logic                     frame_done;

  always #5 clk = ~clk;

  freq_bram_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BINS_W(BINS_W), .IN_W(IN_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .w_en(w_en), .w_addr(w_addr),
    .d_in(d_in), .top_row(top_row), .frame_done(frame_done)
  );

  typedef struct {
    bit we;
    int addr;
    int data;
    bit fd;
    int top;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  sb_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   last_fd_cyc = 0;
  int   last_acc_cyc = 0;
  int   ready_low_cnt = 0;
  int   exp_row = 0;
  logic [IN_W-1:0] frame_data [64];
  logic [DATA_W-1:0] obs_mem [512];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference scaling: divide by 16, clamp to 255.
  function automatic int sat_ref(input int x);
    int v;
    v = x / 16;
    return (v > 255) ? 255 : v;
  endfunction

  // Scoreboard: every write or frame_done cycle must match the model queue.
  always @(negedge clk) begin
    if (!s_ready && !reset) ready_low_cnt++;
    if (w_en === 1'b1 || frame_done === 1'b1) begin
      if (frame_done === 1'b1) begin
        fd_cnt++;
        last_fd_cyc = cyc;
      end
      if (w_en === 1'b1) obs_mem[w_addr] = d_in;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got w_en=%0b addr=%0d d_in=%0d frame_done=%0b, required no event",
                 w_en, w_addr, d_in, frame_done);
      end else begin
        sb_e = exp_q.pop_front();
        if (w_en !== sb_e.we || frame_done !== sb_e.fd ||
            (sb_e.we && (w_addr !== 9'(sb_e.addr) || d_in !== 8'(sb_e.data))) ||
            (sb_e.fd && top_row !== 4'(sb_e.top))) begin
          errors++;
          $display("FAIL write_event: got w_en=%0b addr=%0d d_in=%0d frame_done=%0b top_row=%0d, required w_en=%0b addr=%0d d_in=%0d frame_done=%0b top_row=%0d",
                   w_en, w_addr, d_in, frame_done, top_row,
                   sb_e.we, sb_e.addr, sb_e.data, sb_e.fd, sb_e.top);
        end else begin
          $display("event cyc=%0d w_en=%0b addr=%0d d_in=%0d frame_done=%0b top_row=%0d",
                   cyc, w_en, w_addr, d_in, frame_done, top_row);
        end
      end
    end
  end

  // Expected events for one frame of n samples stored in frame_data.
  task automatic model_frame(input int n, input bit with_last);
    int wr;
    wr = (n < BINS) ? n : BINS;
    for (int b = 0; b < wr; b++)
      exp_q.push_back('{1'b1, exp_row * BINS + b, sat_ref(int'(frame_data[b])),
                        with_last && n == BINS && b == BINS - 1, exp_row});
    if (with_last) begin
      if (n < BINS) begin
        for (int b = n; b < BINS; b++)
          exp_q.push_back('{1'b1, exp_row * BINS + b, 0, b == BINS - 1, exp_row});
      end else if (n > BINS) begin
        exp_q.push_back('{1'b0, 0, 0, 1'b1, exp_row});
      end
      exp_row = (exp_row + 1) % ROWS;
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      frame_data[i] = ($urandom % 3 == 0) ? IN_W'($urandom) : IN_W'($urandom_range(0, 4095));
  endtask

  task automatic drive_frame(input int n, input bit with_last, input int max_gap);
    bit accepted;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = frame_data[i];
      s_last  = with_last && (i == n - 1);
      accepted = 1'b0;
      for (int t = 0; t < 200 && !accepted; t++) begin
        @(negedge clk);
        accepted = s_ready;
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
      end
      if (!accepted) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got s_ready=0 for 200 cycles, required acceptance of sample %0d", i);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_row = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %0b required 0", s_ready); end
    checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %0b required 0", w_en); end
    checks++; if (w_addr !== '0) begin errors++; $display("FAIL reset_w_addr: got %0d required 0", w_addr); end
    checks++; if (d_in !== '0) begin errors++; $display("FAIL reset_d_in: got %0d required 0", d_in); end
    checks++; if (top_row !== '0) begin errors++; $display("FAIL reset_top_row: got %0d required 0", top_row); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b required 0", frame_done); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_row = 0;
    @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_after_release: got %0b required 0", s_ready); end
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_first_cycle: got %0b required 1", s_ready); end
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    int fd0;
    fd0 = fd_cnt;
    for (int k = 0; k < BINS; k++) frame_data[k] = IN_W'(16 * k);
    model_frame(BINS, 1'b1);
    drive_frame(BINS, 1'b1, 2);
    wait_drain();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_drain: got %0d pending required 0", exp_q.size()); end
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL full_fd_count: got %0d required 1", fd_cnt - fd0); end
    checks++; if (last_fd_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL full_fd_timing: got %0d required %0d", last_fd_cyc, last_acc_cyc + 1); end
    checks++; if (top_row !== 4'd0) begin errors++; $display("FAIL full_top_row: got %0d required 0", top_row); end
    $display("test_full_frame done");
  endtask

  task automatic test_saturation();
    int base;
    base = exp_row * BINS;
    fill_random(BINS);
    frame_data[0] = 16'hFFFF;
    frame_data[1] = 16'h0FF0;
    frame_data[2] = 16'h00F0;
    frame_data[3] = 16'h1000;
    frame_data[4] = 16'h0FEF;
    frame_data[5] = 16'h000F;
    model_frame(BINS, 1'b1);
    drive_frame(BINS, 1'b1, 1);
    wait_drain();
    checks++; if (obs_mem[base] !== 8'hFF) begin errors++; $display("FAIL sat_ffff: got %h required ff", obs_mem[base]); end
    checks++; if (obs_mem[base + 1] !== 8'hFF) begin errors++; $display("FAIL sat_0ff0: got %h required ff", obs_mem[base + 1]); end
    checks++; if (obs_mem[base + 2] !== 8'h0F) begin errors++; $display("FAIL sat_00f0: got %h required 0f", obs_mem[base + 2]); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat_drain: got %0d pending required 0", exp_q.size()); end
    $display("test_saturation done");
  endtask

  task automatic test_short_frame(input int n);
    int fd0;
    fd0 = fd_cnt;
    ready_low_cnt = 0;
    fill_random(n);
    model_frame(n, 1'b1);
    drive_frame(n, 1'b1, 1);
    wait_drain();
    checks++; if (ready_low_cnt != BINS - n) begin errors++; $display("FAIL short%0d_ready_low: got %0d required %0d", n, ready_low_cnt, BINS - n); end
    checks++; if (last_fd_cyc != last_acc_cyc + 1 + BINS - n) begin errors++; $display("FAIL short%0d_fd_timing: got %0d required %0d", n, last_fd_cyc, last_acc_cyc + 1 + BINS - n); end
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL short%0d_fd_count: got %0d required 1", n, fd_cnt - fd0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short%0d_drain: got %0d pending required 0", n, exp_q.size()); end
    $display("test_short_frame n=%0d done", n);
  endtask

  task automatic test_long_frame();
    int fd0;
    fd0 = fd_cnt;
    fill_random(40);
    model_frame(40, 1'b1);
    drive_frame(40, 1'b1, 2);
    wait_drain();
    checks++; if (last_fd_cyc != last_acc_cyc + 1) begin errors++; $display("FAIL long_fd_timing: got %0d required %0d", last_fd_cyc, last_acc_cyc + 1); end
    checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL long_fd_count: got %0d required 1", fd_cnt - fd0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL long_drain: got %0d pending required 0", exp_q.size()); end
    $display("test_long_frame done");
  endtask

  task automatic test_back_to_back();
    int fd0, n;
    fd0 = fd_cnt;
    for (int f = 0; f < 12; f++) begin
      n = ($urandom % 2 == 0) ? BINS : int'($urandom_range(1, 40));
      fill_random(n);
      model_frame(n, 1'b1);
      drive_frame(n, 1'b1, 0);
    end
    wait_drain();
    checks++; if (fd_cnt - fd0 != 12) begin errors++; $display("FAIL b2b_fd_count: got %0d required 12", fd_cnt - fd0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending required 0", exp_q.size()); end
    $display("test_back_to_back done");
  endtask

  task automatic test_row_wrap();
    int fd0;
    pulse_reset();
    fd0 = fd_cnt;
    for (int f = 0; f < 17; f++) begin
      fill_random(BINS);
      model_frame(BINS, 1'b1);
      drive_frame(BINS, 1'b1, 0);
    end
    wait_drain();
    checks++; if (fd_cnt - fd0 != 17) begin errors++; $display("FAIL wrap_fd_count: got %0d required 17", fd_cnt - fd0); end
    checks++; if (top_row !== 4'd0) begin errors++; $display("FAIL wrap_top_row: got %0d required 0", top_row); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: got %0d pending required 0", exp_q.size()); end
    $display("test_row_wrap done");
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    for (int f = 0; f < 3; f++) begin
      fill_random(BINS);
      model_frame(BINS, 1'b1);
      drive_frame(BINS, 1'b1, 1);
    end
    fill_random(12);
    model_frame(12, 1'b0);
    drive_frame(12, 1'b0, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL mid_w_en: got %0b required 0", w_en); end
    checks++; if (top_row !== '0) begin errors++; $display("FAIL mid_top_row: got %0d required 0", top_row); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready: got %0b required 0", s_ready); end
    checks++; if (w_addr !== '0 || d_in !== '0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_outputs: got addr=%0d d_in=%0d fd=%0b required 0 0 0", w_addr, d_in, frame_done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_partial_writes: got %0d pending required 0", exp_q.size()); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_row = 0;
    fill_random(BINS);
    model_frame(BINS, 1'b1);
    drive_frame(BINS, 1'b1, 1);
    wait_drain();
    checks++; if (top_row !== 4'd0) begin errors++; $display("FAIL mid_next_top_row: got %0d required 0", top_row); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_drain: got %0d pending required 0", exp_q.size()); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_saturation();
    test_short_frame(10);
    test_long_frame();
    test_short_frame(1);
    test_back_to_back();
    test_reset_mid();
    test_row_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
